iterative_divider_unit: RTL and testbench

Multi-cycle, XLEN-parametrised RV32M/RV64M divider that executes DIV/DIVU/REM/REMU as a restoring radix-2 loop, one quotient bit per cycle. It is the successor of the current divider unit. Additions over that unit:
- an explicit start/valid handshake;
- a flush input;
- RISC-V-exact divide-by-zero and overflow results;
- accuracy-controlled early termination that trades low quotient bits for latency.

It sits in the execute stage beside the multiplier and stalls the pipeline through div_unit_busy.

---
 rtl/iterative_divider_unit_if.sv | 28 ++
 rtl/iterative_divider_unit.sv | 153 +++++++++++++++
 tb/tb_iterative_divider_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iterative_divider_unit_if.sv
// Issue/result bundle of the iterative divider: decoded instruction fields,
// operands, start/flush strobes and the busy/valid/result return path.
interface iterative_divider_unit_if #(
    parameter int XLEN      = 32,
    parameter int ACC_WIDTH = 8
);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [ACC_WIDTH-1:0] accuracy_level;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
    logic                 start;
    logic                 flush;
    logic                 div_unit_busy;
    logic                 div_valid;
    logic [XLEN-1:0]      div_output;

    modport master (
        output opcode, funct3, funct7, accuracy_level, rs1, rs2, start, flush,
        input  div_unit_busy, div_valid, div_output
    );

    modport slave (
        input  opcode, funct3, funct7, accuracy_level, rs1, rs2, start, flush,
        output div_unit_busy, div_valid, div_output
    );
endinterface

// File: rtl/iterative_divider_unit.sv
// Restoring radix-2 RV32M/RV64M divider (DIV/DIVU/REM/REMU), one quotient bit
// per cycle, with optional truncation of low quotient bits to cut latency.
module iterative_divider_unit #(
    parameter int XLEN            = 32,
    parameter int APX_ACC_CONTROL = 1,
    parameter int ACC_WIDTH       = 8
) (
    input logic                   CLK,
    input logic                   reset,
    iterative_divider_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, SPECIAL, DONE} state_t;

    state_t          state;
    logic            busy_q;
    logic            valid_q;
    logic [XLEN-1:0] out_q;
    logic [XLEN-1:0] dividend_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] apx_q;
    logic            is_rem_q;
    logic            neg_q_q;
    logic            neg_r_q;
    logic            dz_q;

    function automatic logic [CNT_W-1:0] clamp_apx(input logic [ACC_WIDTH-1:0] acc);
        int unsigned a;
        a = 32'(acc);
        if (a >= 32'(XLEN - 1)) return CNT_W'(XLEN - 1);
        return CNT_W'(a);
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    // Divide-by-zero and signed overflow results; raw holds the captured rs1.
    function automatic logic [XLEN-1:0] special_result(input logic rem, input logic dz,
                                                       input logic [XLEN-1:0] raw);
        if (rem) return dz ? raw : '0;
        return dz ? '1 : raw;
    endfunction

    logic            decoded;
    logic            accept;
    logic            in_signed;
    logic            in_rem;
    logic            in_s1;
    logic            in_s2;
    logic            in_dz;
    logic            in_ovf;
    logic [CNT_W-1:0] in_apx;

    always_comb begin
        decoded   = (bus.opcode == 7'b0110011) && (bus.funct7 == 7'b0000001) && bus.funct3[2];
        accept    = bus.start && decoded;
        in_signed = !bus.funct3[0];
        in_rem    = bus.funct3[1];
        in_s1     = in_signed && ($signed(bus.rs1) < 0);
        in_s2     = in_signed && ($signed(bus.rs2) < 0);
        in_dz     = (bus.rs2 == '0);
        in_ovf    = in_signed && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
        in_apx    = (!in_rem && APX_ACC_CONTROL != 0) ? clamp_apx(bus.accuracy_level) : '0;
    end

    // One restoring step: the dividend register shifts its MSB into the partial
    // remainder and takes the new quotient bit in at the bottom.
    logic [XLEN:0]   r_shift;
    logic            q_bit;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] dq_next;

    always_comb begin
        r_shift  = {rem_q, dividend_q[XLEN-1]};
        q_bit    = (r_shift >= {1'b0, divisor_q});
        rem_next = q_bit ? (r_shift[XLEN-1:0] - divisor_q) : r_shift[XLEN-1:0];
        dq_next  = {dividend_q[XLEN-2:0], q_bit};
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            apx_q      <= '0;
            is_rem_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            dz_q       <= 1'b0;
        end else if (bus.flush) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        dividend_q <= (in_dz || in_ovf) ? bus.rs1 : apply_sign(bus.rs1, in_s1);
                        divisor_q  <= apply_sign(bus.rs2, in_s2);
                        rem_q      <= '0;
                        cnt_q      <= CNT_W'(XLEN) - in_apx;
                        apx_q      <= in_apx;
                        is_rem_q   <= in_rem;
                        neg_q_q    <= in_s1 ^ in_s2;
                        neg_r_q    <= in_s1;
                        dz_q       <= in_dz;
                        busy_q     <= 1'b1;
                        state      <= (in_dz || in_ovf) ? SPECIAL : CALC;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    dividend_q <= dq_next;
                    rem_q      <= rem_next;
                    cnt_q      <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        out_q   <= is_rem_q ? apply_sign(rem_next, neg_r_q)
                                            : apply_sign(dq_next << apx_q, neg_q_q);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= DONE;
                    end
                end
                SPECIAL: begin
                    out_q   <= special_result(is_rem_q, dz_q, dividend_q);
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= DONE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.div_unit_busy = busy_q;
    assign bus.div_valid     = valid_q;
    assign bus.div_output    = out_q;
endmodule

// File: tb/tb_iterative_divider_unit.sv
// Self-checking bench for iterative_divider_unit: directed scenarios plus
// randomized operations scored against an arithmetic reference model.
module tb_iterative_divider_unit;
    logic CLK;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] last_out;

    iterative_divider_unit_if #(.XLEN(32), .ACC_WIDTH(8)) ifc ();

    iterative_divider_unit #(.XLEN(32), .APX_ACC_CONTROL(1), .ACC_WIDTH(8)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned division, quotient magnitude with the
    // low A bits cleared, RISC-V results for divide-by-zero and overflow.
    function automatic void ref_model(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b, input logic [7:0] acc,
                                      output logic [31:0] res, output int lat);
        bit sgn;
        bit rem;
        longint sa, sb, q, r, qmag;
        int A;
        sgn = (f3[0] == 1'b0);
        rem = f3[1];
        if (b == 32'd0) begin
            res = rem ? a : 32'hFFFF_FFFF;
            lat = 2;
            return;
        end
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = rem ? 32'd0 : a;
            lat = 2;
            return;
        end
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        A  = rem ? 0 : ((acc > 8'd31) ? 31 : int'(acc));
        q  = sa / sb;
        r  = sa % sb;
        qmag = (q < 0) ? -q : q;
        qmag = (qmag >> A) << A;
        q    = (q < 0) ? -qmag : qmag;
        res  = rem ? r[31:0] : q[31:0];
        lat  = 32 - A + 1;
    endfunction

    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] acc);
        ifc.opcode         = 7'b0110011;
        ifc.funct7         = 7'b0000001;
        ifc.funct3         = f3;
        ifc.rs1            = a;
        ifc.rs2            = b;
        ifc.accuracy_level = acc;
        ifc.start          = 1'b1;
    endtask

    // Edge 1 is the accepting edge; valid is expected right after edge exp_lat.
    // A non-zero poke_edge drives an extra decodable start while busy.
    task automatic await_result(input string tag, input logic [31:0] exp, input int exp_lat,
                                input int poke_edge);
        int edges;
        int busy_cnt;
        edges    = 0;
        busy_cnt = 0;
        @(posedge CLK);
        edges = 1;
        #1;
        ifc.start          = 1'b0;
        ifc.rs1            = $urandom;
        ifc.rs2            = $urandom;
        ifc.accuracy_level = 8'($urandom);
        while (ifc.div_valid !== 1'b1 && edges < 120) begin
            if (ifc.div_unit_busy === 1'b1) busy_cnt++;
            if (edges == poke_edge) begin
                ifc.funct3 = 3'b101;
                ifc.rs2    = 32'd0;
                ifc.start  = 1'b1;
            end else begin
                ifc.start = 1'b0;
            end
            @(posedge CLK);
            edges++;
            #1;
        end
        ifc.start = 1'b0;
        check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
        check({tag, "_result"}, 64'(ifc.div_output), 64'(exp));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        last_out = exp;
    endtask

    task automatic op_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [7:0] acc);
        logic [31:0] exp;
        int lat;
        ref_model(f3, a, b, acc, exp, lat);
        @(negedge CLK);
        launch(f3, a, b, acc);
        await_result(tag, exp, lat, 0);
        @(posedge CLK);
        #1;
        check({tag, "_valid_pulse"}, 64'(ifc.div_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] exp;
        int lat;
        logic [2:0] f3;
        logic [31:0] a, b;
        logic [7:0] acc;
        bit seen;

        reset              = 1'b0;
        ifc.opcode         = '0;
        ifc.funct3         = '0;
        ifc.funct7         = '0;
        ifc.accuracy_level = '0;
        ifc.rs1            = '0;
        ifc.rs2            = '0;
        ifc.start          = 1'b0;
        ifc.flush          = 1'b0;
        last_out           = '0;
        #12;
        check("reset_busy", 64'(ifc.div_unit_busy), 64'd0);
        check("reset_valid", 64'(ifc.div_valid), 64'd0);
        check("reset_output", 64'(ifc.div_output), 64'd0);
        @(negedge CLK);
        reset = 1'b1;

        // Directed arithmetic
        op_check("divu_400_20", 3'b101, 32'd400, 32'd20, 8'd0);
        op_check("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 8'd0);
        op_check("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 8'd0);
        op_check("remu_500_20_acc4", 3'b111, 32'd500, 32'd20, 8'd4);
        op_check("divu_by_zero", 3'b101, 32'd100, 32'd0, 8'd0);
        op_check("remu_by_zero", 3'b111, 32'd100, 32'd0, 8'd0);
        op_check("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 8'd0);
        op_check("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 8'd0);
        op_check("divu_apx4", 3'b101, 32'd500, 32'd20, 8'd4);
        op_check("divu_apx200", 3'b101, 32'd500, 32'd20, 8'd200);

        // Non-M encoding must not start anything
        @(negedge CLK);
        launch(3'b101, 32'd9, 32'd3, 8'd0);
        ifc.funct7 = 7'b0000000;
        @(posedge CLK);
        #1;
        ifc.start = 1'b0;
        check("bad_funct7_busy", 64'(ifc.div_unit_busy), 64'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("bad_funct7_valid", 64'(ifc.div_valid), 64'd0);
        check("bad_funct7_hold", 64'(ifc.div_output), 64'(last_out));

        // Back-to-back: second op issued during the DONE cycle of the first
        @(negedge CLK);
        launch(3'b101, 32'd1000, 32'd7, 8'd0);
        await_result("b2b_first", 32'd142, 33, 0);
        launch(3'b110, 32'hFFFF_FF9C, 32'd7, 8'd0);
        await_result("b2b_second", 32'hFFFF_FFFE, 33, 0);

        // Start while busy is ignored
        @(negedge CLK);
        launch(3'b101, 32'd400, 32'd20, 8'd0);
        await_result("busy_ignore", 32'd20, 33, 5);
        @(posedge CLK);
        #1;
        check("busy_ignore_idle", 64'(ifc.div_unit_busy), 64'd0);

        // Flush at cycle 10 of a DIV, with a simultaneous start that is dropped
        @(negedge CLK);
        launch(3'b100, 32'd12345, 32'd11, 8'd0);
        @(posedge CLK);
        #1;
        ifc.start = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        ifc.flush = 1'b1;
        launch(3'b101, 32'd50, 32'd5, 8'd0);
        @(posedge CLK);
        #1;
        ifc.flush = 1'b0;
        ifc.start = 1'b0;
        check("flush_busy", 64'(ifc.div_unit_busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ifc.div_valid === 1'b1 || ifc.div_unit_busy === 1'b1) seen = 1'b1;
            @(posedge CLK);
            #1;
        end
        check("flush_no_activity", 64'(seen), 64'd0);
        check("flush_hold_output", 64'(ifc.div_output), 64'(last_out));

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            f3 = 3'b100 | 3'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 16));
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            acc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            ref_model(f3, a, b, acc, exp, lat);
            @(negedge CLK);
            launch(f3, a, b, acc);
            await_result($sformatf("rand%0d_f3_%0d", i, f3), exp, lat, 0);
        end

        // Asynchronous reset in the middle of CALC
        @(negedge CLK);
        launch(3'b101, 32'd400, 32'd20, 8'd0);
        @(posedge CLK);
        #1;
        ifc.start = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_busy", 64'(ifc.div_unit_busy), 64'd0);
        check("midreset_valid", 64'(ifc.div_valid), 64'd0);
        check("midreset_output", 64'(ifc.div_output), 64'd0);
        @(negedge CLK);
        reset = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        check("midreset_no_valid", 64'(ifc.div_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
